// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and register index type used by the operand fetch slice.
package cpu_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
// A set and a clear on the same register in one cycle leaves it set; bit 0 never sets.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 clr_en_i,
    input  logic [AW-1:0]        clr_idx_i,
    input  logic                 set_en_i,
    input  logic [AW-1:0]        set_idx_i,
    output logic [(1<<AW)-1:0]   busy_o
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        // Applied after the clear: the instruction being issued is younger than the writeback.
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch between decode and execute: drives the register file read ports,
// bypasses same-cycle writebacks, stalls on RAW/WAW against the busy scoreboard.
module rf_operand_fetch #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int AW   = cpu_pkg::REG_AW,
    parameter int PW   = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_wen_rd,
    input  logic [PW-1:0]   in_payload,

    output logic            rf_re1,
    output logic            rf_re2,
    output logic [AW-1:0]   rf_raddr1,
    output logic [AW-1:0]   rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,

    input  logic            wb_we,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd,
    output logic            out_wen_rd,
    output logic [PW-1:0]   out_payload
);

    import cpu_pkg::*;

    localparam int NREG = 1 << AW;

    function automatic logic [XLEN-1:0] sel_operand(
        input logic            use_rs,
        input logic [AW-1:0]   rs,
        input logic            hit,
        input logic [XLEN-1:0] bypass_data,
        input logic [XLEN-1:0] rf_data
    );
        logic [XLEN-1:0] op;
        op = '0;
        if (use_rs && (rs != '0)) begin
            op = hit ? bypass_data : rf_data;
        end
        return op;
    endfunction

    logic [NREG-1:0] busy;

    logic hit_rs1, hit_rs2, hit_rd;
    logic raw_rs1, raw_rs2, waw;
    logic hazard;
    logic fire;
    logic set_en;

    logic [XLEN-1:0] op1_sel, op2_sel;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            wen_q, wen_d;
    logic [PW-1:0]   payload_q, payload_d;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;
    assign rf_re1    = in_valid & in_use_rs1;
    assign rf_re2    = in_valid & in_use_rs2;

    assign hit_rs1 = wb_we && (wb_waddr == in_rs1);
    assign hit_rs2 = wb_we && (wb_waddr == in_rs2);
    assign hit_rd  = wb_we && (wb_waddr == in_rd);

    // A writeback landing this cycle resolves the hazard immediately; no bubble.
    assign raw_rs1 = in_use_rs1 && (in_rs1 != '0) && busy[in_rs1] && !hit_rs1;
    assign raw_rs2 = in_use_rs2 && (in_rs2 != '0) && busy[in_rs2] && !hit_rs2;
    assign waw     = in_wen_rd && (in_rd != '0) && busy[in_rd] && !hit_rd;
    assign hazard  = raw_rs1 | raw_rs2 | waw;

    assign in_ready = !hazard && (!out_valid_q || out_ready) && !flush;
    assign fire     = in_valid && in_ready;
    assign set_en   = fire && in_wen_rd && (in_rd != '0);

    always_comb begin
        op1_sel = sel_operand(in_use_rs1, in_rs1, hit_rs1, wb_wdata, rf_rdata1);
        op2_sel = sel_operand(in_use_rs2, in_rs2, hit_rs2, wb_wdata, rf_rdata2);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rd_d        = rd_q;
        wen_d       = wen_q;
        payload_d   = payload_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            op1_d       = op1_sel;
            op2_d       = op2_sel;
            rd_d        = in_rd;
            wen_d       = in_wen_rd;
            payload_d   = in_payload;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            payload_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rd_q        <= rd_d;
            wen_q       <= wen_d;
            payload_q   <= payload_d;
        end
    end

    rf_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .clr_en_i  (wb_we),
        .clr_idx_i (wb_waddr),
        .set_en_i  (set_en),
        .set_idx_i (in_rd),
        .busy_o    (busy)
    );

    assign out_valid   = out_valid_q;
    assign out_op1     = op1_q;
    assign out_op2     = op2_q;
    assign out_rd      = rd_q;
    assign out_wen_rd  = wen_q;
    assign out_payload = payload_q;

endmodule

// File: doc/rf_operand_fetch.md
# rf_operand_fetch

- Initiator side of the 32x32 register file's read ports.
- Accepts decoded instructions over a valid/ready handshake and drives `rf_re1`/`rf_raddr1` and `rf_re2`/`rf_raddr2`.
- Bypasses same-cycle writeback data and tracks pending destinations in a busy-bit scoreboard, stalling on RAW/WAW hazards.
- Presents registered operands to the execute stage; sits between decode and execute.

## Interface
Parameters:
- `XLEN`, 32, data width
- `AW`, 5, register address width (2^AW registers)
- `PW`, 64, opaque payload width carried alongside operands

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  kill output register and clear scoreboard
- `in_valid`  in  1  decoded instruction valid
- `in_ready`  out  1  instruction accepted this cycle when high with `in_valid`
- `in_rs1`, `in_rs2`  in  AW  source register numbers
- `in_use_rs1`, `in_use_rs2`  in  1  source actually read
- `in_rd`  in  AW  destination register
- `in_wen_rd`  in  1  instruction writes `in_rd`
- `in_payload`  in  PW  passthrough
- `rf_re1`, `rf_re2`  out  1  register file read enables
- `rf_raddr1`, `rf_raddr2`  out  AW  register file read addresses
- `rf_rdata1`, `rf_rdata2`  in  XLEN  register file read data, combinational
- `wb_we`  in  1  writeback snoop; same signal as register file write enable
- `wb_waddr`  in  AW  writeback snoop address
- `wb_wdata`  in  XLEN  writeback snoop data
- `out_valid`  out  1  operands valid
- `out_ready`  in  1  execute accepts
- `out_op1`, `out_op2`  out  XLEN  resolved operands
- `out_rd`  out  AW  registered destination
- `out_wen_rd`  out  1  registered destination write enable
- `out_payload`  out  PW  registered passthrough

## Operation
Register file read addressing:
- `rf_raddr1 = in_rs1`, `rf_re1 = in_valid & in_use_rs1`; port 2 likewise.

Operand select, per source, in priority order:
- Unused source -> 0.
- `rs == 0` -> 0. Register 0 is forced to zero here; the register file does not force it.
- `wb_we & wb_waddr == rs` -> `wb_wdata` (bypass; the register file updates only at the edge).
- Otherwise -> `rf_rdata`.

Scoreboard: `busy[2^AW]`, bit 0 hardwired 0.
- `bypass_hit(r) = wb_we & wb_waddr == r`.
- `raw(rsN) = use_rsN & rsN != 0 & busy[rsN] & !bypass_hit(rsN)`.
- `waw = in_wen_rd & in_rd != 0 & busy[in_rd] & !bypass_hit(in_rd)`.
- `hazard = raw(rs1) | raw(rs2) | waw`.

Handshake:
- `in_ready = !hazard & (!out_valid | out_ready) & !flush`.
- `fire = in_valid & in_ready`.
- On fire: load the output register, set `out_valid`.
- Else if `out_ready`: clear `out_valid`.
- Output data holds while `out_valid & !out_ready`.

Busy update each edge:
- Clear `busy[wb_waddr]` when `wb_we`.
- Then set `busy[in_rd]` when `fire & in_wen_rd & in_rd != 0`.
- Set wins over clear on the same register in the same cycle (the incoming instruction is younger).

Flush:
- Next edge: `out_valid = 0`, all busy bits = 0.
- `in_ready` is forced low that cycle, so nothing is accepted.

Writebacks:
- Writebacks with `wb_waddr == 0` affect nothing.
- Writebacks to non-busy registers are legal (bypass still applies).

## Timing
- Latency: accepted in cycle N -> `out_valid` with operands in cycle N+1.
- Throughput: 1 instruction per cycle with no hazard and `out_ready` held high.
- Hazard resolution: a writeback in cycle N to the blocking register makes `in_ready` high in cycle N, via combinational bypass. Zero bubble after writeback.
- `in_ready` is combinational from `in_*`, `wb_*`, `out_ready`, `flush`, state. No combinational path from `rf_rdata` to `in_ready`.
- Reset values: `out_valid = 0`, `out_op1 = out_op2 = 0`, `out_rd = 0`, `out_wen_rd = 0`, `out_payload = 0`, busy all 0.
- `rf_re*` follow `in_valid`, so they are 0 after reset until `in_valid` rises.
- `rst` mid-operation: identical to flush plus data clear; it takes priority over `flush` and `fire`.

## Structure
- Shared package `cpu_pkg`: `XLEN`, `REG_AW`, `REG_ZERO = 0`, typedef `reg_idx_t`.
- Sub-module `rf_scoreboard`:
  - Inputs: set/clear ports, flush.
  - Outputs: busy vector.
  - Implements set-wins rule and hardwired bit 0.
- Operand mux and handshake stay in `rf_operand_fetch`.

## Test plan
- RF pre-loaded x5 = 0x11, x6 = 0x22. Issue rs1 = 5, rs2 = 6, rd = 7 -> next cycle `out_op1 = 0x11`, `out_op2 = 0x22`, `busy[7] = 1`.
- RAW stall:
  - Issue rd = 7, then rs1 = 7 -> `in_ready = 0`.
  - Drive `wb_we = 1`, `wb_waddr = 7`, `wb_wdata = 0xDEAD` -> `in_ready = 1` the same cycle.
  - Next cycle `out_op1 = 0xDEAD`, `busy[7] = 0`.
- x0: RF entry 0 pre-loaded 0xFFFF_FFFF; issue rs1 = 0, rd = 0 -> `out_op1 = 0`, `busy[0]` stays 0, never stalls.
- Same-cycle set/clear: writeback x9 while accepting an instruction with rd = 9 -> `busy[9] = 1` afterward. Next rs1 = 9 stalls.
- Backpressure: `out_ready = 0` for 3 cycles with valid input -> outputs stable, `in_ready = 0`, no busy changes. On release, one transfer per cycle.
- Flush: with `busy[3]` and `busy[4]` set and `out_valid = 1`, assert `flush` -> next cycle `out_valid = 0`, busy all 0. An instruction reading x3 is accepted without stall.
